// File: rtl/pll_reset_sequencer_pkg.sv
// rtl/pll_reset_sequencer_pkg.sv - shared state encoding and helpers for the PLL reset sequencer
package pll_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        STAGGER   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - generic single-bit synchroniser with synchronous active-low clear
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic clear_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // shift the asynchronous input through the flop chain; clear drops every stage to 0
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - waits for a stable PLL lock, then releases peripheral and core resets in turn
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_CYCLES    = 65536,
    parameter int STAGGER_CYCLES = 256,
    parameter int LOSS_CNT_W     = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    output logic                  periph_reset,
    output logic                  core_reset,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int CNT_W = $clog2(max_int(LOCK_CYCLES, STAGGER_CYCLES) + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("pll_reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
        $error("pll_reset_sequencer: LOCK_CYCLES must be >= 1");
    end
    if (STAGGER_CYCLES < 1) begin : g_bad_stagger_cycles
        $error("pll_reset_sequencer: STAGGER_CYCLES must be >= 1");
    end
    if (LOSS_CNT_W < 1) begin : g_bad_loss_cnt_w
        $error("pll_reset_sequencer: LOSS_CNT_W must be >= 1");
    end

    logic             locked_s;
    seq_state_t       state;
    logic [CNT_W-1:0] cnt;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clock   (clock),
        .clear_n (reset_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    // sequencing FSM sharing one counter for both the lock window and the stagger gap
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            periph_reset <= 1'b1;
            core_reset   <= 1'b1;
            ready        <= 1'b0;
            loss_count   <= '0;
        end else begin
            unique case (state)
                WAIT_LOCK: begin
                    periph_reset <= 1'b1;
                    core_reset   <= 1'b1;
                    ready        <= 1'b0;
                    if (locked_s) begin
                        state <= STABILIZE;
                        cnt   <= '0;
                    end
                end
                STABILIZE: begin
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                    end else if (cnt == LOCK_LAST) begin
                        state        <= STAGGER;
                        cnt          <= '0;
                        periph_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STAGGER: begin
                    if (!locked_s) begin
                        state        <= WAIT_LOCK;
                        periph_reset <= 1'b1;
                    end else if (cnt == STAGGER_LAST) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                        ready      <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state        <= WAIT_LOCK;
                        periph_reset <= 1'b1;
                        core_reset   <= 1'b1;
                        ready        <= 1'b0;
                        if (loss_count != '1) begin
                            loss_count <= loss_count + LOSS_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                end
            endcase
        end
    end

endmodule
